// File: rtl/mem_printer.sv
// Memory-mapped character printer: DATA writes push byte lanes into a FIFO drained by a valid/ready sink.
// Latency: response one cycle after accept; a pushed byte reaches char_data_o on the cycle after the write.
// Backpressure: BLOCKING=1 holds accept low while a DATA write does not fit; BLOCKING=0 drops and counts it.
module mem_printer #(
  parameter logic [31:0] ADDR_START = 32'h10000000,
  parameter int          FIFO_DEPTH = 16,
  parameter bit          BLOCKING   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic [10:0] mem_d_req_tag_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic [10:0] mem_d_resp_tag_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  // Registered state
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [7:0]    fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [14:0]   drop_q, drop_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [10:0]   tag_q, tag_d;

  // Request decode
  logic          is_req;
  logic [1:0]    offset;
  logic          bad_req;
  logic          data_wr;
  logic          ctrl_wr;
  logic          status_rd;
  logic [2:0]    lane_cnt;
  logic [LW-1:0] free_cnt;
  logic          fits;
  logic          accept;
  logic          do_push;
  logic          drop_event;
  logic          pop;
  logic [31:0]   status_word;

  // Only the offset bits are decoded; the window base is resolved upstream.
  logic unused_addr;
  assign unused_addr = ^{ADDR_START, mem_d_addr_i[31:4], mem_d_addr_i[1:0]};

  always_comb begin
    is_req    = mem_d_rd_i | (|mem_d_wr_i);
    offset    = mem_d_addr_i[3:2];
    bad_req   = is_req & ((offset == 2'd3) | (mem_d_rd_i & (|mem_d_wr_i)));
    data_wr   = is_req & ~bad_req & (offset == OFF_DATA) & (|mem_d_wr_i);
    ctrl_wr   = is_req & ~bad_req & (offset == OFF_CTRL) & (|mem_d_wr_i);
    status_rd = is_req & ~bad_req & (offset == OFF_STATUS) & mem_d_rd_i;

    lane_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      lane_cnt = lane_cnt + {2'b00, mem_d_wr_i[i]};
    end

    // Free space uses the registered level only: a pop this cycle is not credited.
    free_cnt = LW'(FIFO_DEPTH) - level_q;
    fits     = (LW'(lane_cnt) <= free_cnt);

    accept     = is_req & ~rst_i & ~(BLOCKING & data_wr & ~fits);
    do_push    = accept & data_wr & fits;
    drop_event = accept & data_wr & ~fits;

    status_word = {ovf_q, drop_q, {(16 - LW){1'b0}}, level_q};
  end

  assign mem_d_accept_o = accept;

  // FIFO push / pop
  assign char_valid_o = (level_q != '0) & ~rst_i;
  assign char_data_o  = fifo_mem_q[rd_ptr_q];
  assign pop          = char_valid_o & char_ready_i;

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    // Enabled lanes land in consecutive slots, lane 0 first.
    if (do_push) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_d_wr_i[i]) begin
          fifo_mem_d[wr_ptr_d] = mem_d_data_wr_i[8*i +: 8];
          wr_ptr_d             = wr_ptr_d + PW'(1);
        end
      end
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + (do_push ? LW'(lane_cnt) : '0) - LW'(pop);
  end

  // Overflow / drop bookkeeping; a clear takes precedence over a drop.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop_event) begin
      ovf_d = 1'b1;
      if (drop_q != 15'h7FFF) begin
        drop_d = drop_q + 15'd1;
      end
    end
    if (ctrl_wr && accept) begin
      ovf_d  = 1'b0;
      drop_d = 15'd0;
    end
  end

  // Response channel
  always_comb begin
    ack_d   = accept;
    err_d   = accept & bad_req;
    tag_d   = accept ? mem_d_req_tag_i : tag_q;
    rdata_d = (accept && status_rd) ? status_word : 32'd0;
  end

  assign mem_d_ack_o      = ack_q;
  assign mem_d_error_o    = err_q;
  assign mem_d_data_rd_o  = rdata_q;
  assign mem_d_resp_tag_o = tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      tag_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      tag_q    <= tag_d;
    end
  end

  // Character storage is not reset; the pointers and level define validity.
  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: doc/mem_printer.md
MEM_PRINTER -- requirements
Module: mem_printer

Interface
REQ-001 SHALL have parameter ADDR_START, default 32'h10000000: base of the register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: character FIFO entries; power of 2, minimum 4.
REQ-003 SHALL have parameter BLOCKING, default 1: 1 = stall when the FIFO is full; 0 = drop and count.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port mem_d_addr_i, input, 32: request byte address; only offset bits [3:2] are decoded.
REQ-007 SHALL have port mem_d_data_wr_i, input, 32: write data; byte lane n = bits [8n+7:8n].
REQ-008 SHALL have port mem_d_rd_i, input, 1: read request.
REQ-009 SHALL have port mem_d_wr_i, input, 4: per-lane write strobes.
REQ-010 SHALL have port mem_d_req_tag_i, input, 11: request tag.
REQ-011 SHALL have port mem_d_accept_o, output, 1: request accepted this cycle.
REQ-012 SHALL have port mem_d_ack_o, output, 1: response valid.
REQ-013 SHALL have port mem_d_error_o, output, 1: response error.
REQ-014 SHALL have port mem_d_data_rd_o, output, 32: read response data.
REQ-015 SHALL have port mem_d_resp_tag_o, output, 11: echoed request tag.
REQ-016 SHALL have port char_valid_o, output, 1: FIFO head valid.
REQ-017 SHALL have port char_data_o, output, 8: FIFO head character.
REQ-018 SHALL have port char_ready_i, input, 1: sink consumes the head when high together with char_valid_o.

Function
REQ-019 SHALL define the register map by offset: 0x0 DATA (write pushes bytes; read returns 0); 0x4 STATUS (read-only); 0x8 CTRL (any write clears overflow and drop count; read returns 0); 0xC unmapped.
REQ-020 SHALL define a request as mem_d_rd_i=1 or mem_d_wr_i!=0.
- The block decodes only offset bits; the external decoder guarantees the address is in the window.
REQ-021 SHALL, on a DATA write, push the enabled lanes in ascending lane order (0..3), up to 4 bytes per cycle.
- Example: strobes 4'b1010 push lane1, then lane3.
REQ-022 SHALL compute free = FIFO_DEPTH - level from the registered level; a same-cycle pop is not credited.
REQ-023 SHALL, with BLOCKING=1, hold mem_d_accept_o=0 for a DATA write while popcount(mem_d_wr_i) > free; all other requests are accepted immediately.
REQ-024 SHALL, with BLOCKING=0, always accept.
- DATA write with popcount > free: push no bytes, set overflow (sticky), increment the drop count by 1.
- Drop count is 15 bits and saturates at 0x7FFF.
REQ-025 SHALL drive the response exactly 1 cycle after accept: mem_d_ack_o=1 for one cycle, with the resp tag equal to the accepted req tag.
- Back-to-back accepts produce back-to-back acks.
REQ-026 SHALL format STATUS read data as: [31] overflow, [30:16] drop count, [15:0] level sampled in the accept cycle, zero-extended.
REQ-027 SHALL, for a request to 0xC, or one with mem_d_rd_i and mem_d_wr_i both active: accept, then ack with mem_d_error_o=1, data 0, no side effect.
REQ-028 SHALL drive char_valid_o = (level != 0) and char_data_o = head entry.
- Pop when char_valid_o & char_ready_i.
- Pop and push in the same cycle are both honoured: new level = level + pushed - popped.
REQ-029 SHALL keep level in range [0, FIFO_DEPTH]; level is log2(FIFO_DEPTH)+1 bits wide.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Full: level = FIFO_DEPTH. Empty: level = 0.
REQ-030 SHALL, when a CTRL clear coincides with an overflow event in the same cycle, let the clear win: overflow=0, count=0.

Reset
REQ-031 SHALL, while rst_i=1 at a clock edge, clear the following: pointers, level, overflow, drop count, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o.
REQ-032 SHALL drive mem_d_accept_o=0 and char_valid_o=0 during reset.
REQ-033 SHALL, on reset asserted mid-operation, discard all FIFO contents and any pending ack; FIFO RAM contents need not be cleared.

Verification
REQ-034 SHALL verify: write 0x0A6F6948 to DATA, strobes 4'hF, char_ready_i=1 -> ack next cycle with error=0; chars 0x48, 0x69, 0x6F, 0x0A in order, on 4 consecutive cycles.
REQ-035 SHALL verify: BLOCKING=1, DEPTH=4, char_ready_i=0 -> first 4-byte write accepted, second stalls (accept=0); raise ready -> second write accepted only once level=0.
REQ-036 SHALL verify: BLOCKING=0, DEPTH=4, ready=0, three 4-byte writes -> STATUS read returns 0x80020004; CTRL write then STATUS -> 0x00000004.
REQ-037 SHALL verify: read 0xC with tag 0x155 -> ack with error=1, resp tag 0x155, data 0.
REQ-038 SHALL verify: strobes 4'b0101, data 0x00420041 -> chars 0x41 then 0x42, level never exceeds 2.
REQ-039 SHALL verify: rst_i pulsed with level=3 -> char_valid_o=0 and STATUS reads 0 afterwards.
